// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM states and sizing helpers for the multiply/divide unit.
package mdu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational {hi,lo} result for the latched MDU operation.
// Divider datapath only exists when MDU_DIV_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]          i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_result
);

    logic [2*DATA_W-1:0] w_smul;
    logic [2*DATA_W-1:0] w_umul;

    assign w_smul = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) * $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

`ifdef MDU_DIV_EN
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W-1:0] w_q_mag;
    logic [DATA_W-1:0] w_r_mag;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;

    // Divide magnitudes unsigned and re-apply signs: gives truncation toward
    // zero and makes 0x80000000 / -1 wrap to 0x80000000 with no special case.
    assign w_a_neg = (i_op == OP_DIV) && i_a[DATA_W-1];
    assign w_b_neg = (i_op == OP_DIV) && i_b[DATA_W-1];
    assign w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quo   = (i_b == 32'd0) ? 32'hFFFF_FFFF
                   : ((w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag);
    assign w_rem   = (i_b == 32'd0) ? i_a
                   : (w_a_neg ? (32'd0 - w_r_mag) : w_r_mag);
`endif

    // Select the result for the latched op.
    always_comb begin
        o_result = 64'd0;
        case (i_op)
            OP_MULT:  o_result = w_smul;
            OP_MULTU: o_result = w_umul;
`ifdef MDU_DIV_EN
            OP_DIV,
            OP_DIVU:  o_result = {w_rem, w_quo};
`endif
            default:  o_result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and an IDLE/BUSY FSM.
// Define MDU_DIV_EN to enable DIV/DIVU; otherwise ops 2/3 are ignored.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_busy;

    logic                w_start_mul;
    logic                w_start_div;
    logic [2*DATA_W-1:0] w_result;

    assign w_start_mul = start && is_mul_op(op);
`ifdef MDU_DIV_EN
    assign w_start_div = start && is_div_op(op);
`else
    assign w_start_div = 1'b0;
`endif

    mdu_calc u_calc (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result)
    );

    // FSM, cycle counter, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_mul || w_start_div) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= w_start_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end else if (start && (op == OP_MTHI)) begin
                        r_hi <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        r_lo <= a;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Any start here is dropped; the pipeline stalls on busy.
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= w_result[2*DATA_W-1:DATA_W];
                        r_lo    <= w_result[DATA_W-1:0];
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed scoreboard bench for mdu: expected {hi,lo} queued at issue, checked at commit.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;
    logic [63:0] sb[$];

    mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int ncyc, input logic [63:0] exp_res,
                          input logic inj);
        logic [31:0] hi0;
        logic [31:0] lo0;
        logic        held;
        logic [63:0] e;
        int          cnt;
        hi0  = hi;
        lo0  = lo;
        held = 1'b1;
        cnt  = 0;
        sb.push_back(exp_res);
        issue(o, x, y);
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            if (inj && cnt == 2) begin
                start = 1'b1;
                op    = OP_MTLO;
                a     = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(ncyc));
        check({tag, "_hold"}, {63'd0, held}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    endtask

    initial begin
        logic [31:0] h0;
        logic [31:0] l0;
        logic        seen;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        n_tests = 0;
        n_fail  = 0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);

        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        check("mthi_lo", {32'd0, lo}, 64'd0);
        check("mthi_busy", {63'd0, busy}, 64'd0);

        issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
        check("mtlo_lo", {32'd0, lo}, 64'hCAFE_F00D);
        check("mtlo_hi", {32'd0, hi}, 64'h1234_5678);

        run_op("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, MUL_N, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        run_op("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_N, 64'h0000_0001_FFFF_FFFE, 1'b1);
        run_op("mult_neg_neg", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFF9, MUL_N, 64'd35, 1'b0);
        run_op("multu_big", OP_MULTU, 32'h8000_0000, 32'h8000_0000, MUL_N, 64'h4000_0000_0000_0000, 1'b0);

`ifdef MDU_DIV_EN
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, DIV_N, 64'h0000_0007_FFFF_FFFF, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 64'h0000_0000_8000_0000, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_N, 64'h0000_0001_FFFF_FFFD, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, DIV_N, 64'h0000_0001_7FFF_FFFC, 1'b0);
`else
        h0 = hi;
        l0 = lo;
        issue(OP_DIV, 32'd8, 32'd2);
        check("nodiv_busy", {63'd0, busy}, 64'd0);
        issue(OP_DIVU, 32'd9, 32'd3);
        check("nodivu_busy", {63'd0, busy}, 64'd0);
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        check("nodiv_hi", {32'd0, hi}, {32'd0, h0});
        check("nodiv_lo", {32'd0, lo}, {32'd0, l0});
`endif

        h0 = hi;
        l0 = lo;
        issue(OP_RSV6, 32'h5555_AAAA, 32'd1);
        issue(OP_RSV7, 32'hAAAA_5555, 32'd1);
        check("rsv_busy", {63'd0, busy}, 64'd0);
        check("rsv_hilo", {hi, lo}, {h0, l0});

        issue(OP_MULT, 32'd100, 32'd100);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        seen = 1'b0;
        repeat (MUL_N + 5) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
        end
        check("abort_no_commit", {63'd0, seen}, 64'd0);

        run_op("mult_after_rst", OP_MULT, 32'd6, 32'd7, MUL_N, 64'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
